// File: rtl/gpc_pkg.sv
// gpc_pkg
//   Shared definitions for the GPC front end: fetch FSM state encoding,
//   instruction size in bytes and the canonical NOP encoding.
// Ports: none (package).
package gpc_pkg;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned INST_BYTES = 4;

  // addi x0, x0, 0 -- reserved for bubble insertion by later stages
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/gpc_fetch_ctrl.sv
// gpc_fetch_ctrl
//   Instruction-fetch sequencer. Owns the fetch PC, issues one request at a
//   time on the instruction-memory port, and presents each returned
//   instruction with its PC to the core over a valid/ready handshake.
//   Redirects from execute replace the fetch PC; a fetch already granted
//   is marked killed and its single response is dropped.
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   mem_req/mem_addr/mem_gnt   request channel to instruction memory
//   mem_rvalid/mem_rdata       response channel from instruction memory
//   redirect_valid/_pc         PC change request from execute
//   inst_valid/inst/inst_pc    instruction to core, inst_ready consumes it
//   fetch_cnt                  completed core handshakes (wraps)
//
// state   | meaning
// --------+---------------------------------------------------------------
// FS_REQ  | request fetch_pc on the memory port, wait for mem_gnt
// FS_WAIT | request granted, wait for mem_rvalid (dropped if kill set)
// FS_HOLD | instruction presented to core, wait for inst_ready/redirect
module gpc_fetch_ctrl #(
  parameter int unsigned        WIDTH    = 32,
  parameter int unsigned        INST_MAX = 32,
  parameter logic [WIDTH-1:0]   PC_START = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req,
  output logic [WIDTH-1:0]    mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [INST_MAX-1:0] mem_rdata,
  input  logic                redirect_valid,
  input  logic [WIDTH-1:0]    redirect_pc,
  output logic                inst_valid,
  output logic [INST_MAX-1:0] inst,
  output logic [WIDTH-1:0]    inst_pc,
  input  logic                inst_ready,
  output logic [31:0]         fetch_cnt
);

  import gpc_pkg::*;

  fetch_state_e        state_q, state_d;
  logic [WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0]    pend_pc_q, pend_pc_d;
  logic                pend_q, pend_d;
  logic                kill_q, kill_d;
  logic                mem_req_q, mem_req_d;
  logic                inst_valid_q, inst_valid_d;
  logic [INST_MAX-1:0] inst_q, inst_d;
  logic [WIDTH-1:0]    inst_pc_q, inst_pc_d;
  logic [31:0]         fetch_cnt_q, fetch_cnt_d;

  logic [WIDTH-1:0]    redir_tgt;

  // Fetch addresses are always word aligned.
  assign redir_tgt = redirect_pc & ~(WIDTH'(2'b11));

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    pend_d       = pend_q;
    kill_d       = kill_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    fetch_cnt_d  = fetch_cnt_q;

    case (state_q)
      FS_REQ: begin
        if (mem_req_q && mem_gnt) begin
          state_d = FS_WAIT;
          // The granted fetch belongs to the old PC; mark it for discard.
          if (redirect_valid) begin
            kill_d     = 1'b1;
            fetch_pc_d = redir_tgt;
            pend_d     = 1'b0;
          end else if (pend_q) begin
            kill_d     = 1'b1;
            fetch_pc_d = pend_pc_q;
            pend_d     = 1'b0;
          end
        end else if (redirect_valid) begin
          // A live request must keep its address until granted, so park the
          // target. Before the first request is driven it can be taken directly.
          if (mem_req_q) begin
            pend_d    = 1'b1;
            pend_pc_d = redir_tgt;
          end else begin
            fetch_pc_d = redir_tgt;
          end
        end
      end

      FS_WAIT: begin
        if (redirect_valid) begin
          kill_d     = 1'b1;
          fetch_pc_d = redir_tgt;
        end
        if (mem_rvalid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = FS_REQ;
          end else begin
            inst_d       = mem_rdata;
            inst_pc_d    = fetch_pc_q;
            inst_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + WIDTH'(INST_BYTES);
            state_d      = FS_HOLD;
          end
        end
      end

      FS_HOLD: begin
        if (inst_ready) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (inst_ready || redirect_valid) begin
          inst_valid_d = 1'b0;
          state_d      = FS_REQ;
        end
        if (redirect_valid) begin
          fetch_pc_d = redir_tgt;
        end
      end

      default: begin
        state_d = FS_REQ;
      end
    endcase

    mem_req_d = (state_d == FS_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FS_REQ;
      fetch_pc_q   <= PC_START;
      pend_pc_q    <= '0;
      pend_q       <= 1'b0;
      kill_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_q       <= pend_d;
      kill_q       <= kill_d;
      mem_req_q    <= mem_req_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = fetch_pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_gpc_fetch_ctrl.sv
// tb_gpc_fetch_ctrl
//   Directed bench for gpc_fetch_ctrl. Inputs change and outputs are sampled
//   on the falling edge. Expected instructions are queued when a response
//   that should be delivered is driven, and popped when inst_valid appears.
module tb_gpc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] fetch_cnt;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_cnt  = 0;

  always #5 clk = ~clk;

  gpc_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fetch_cnt      (fetch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the presented instruction against the scoreboard head.
  task automatic check_out();
    chk("inst_valid_set", {31'd0, inst_valid}, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=inst %h expected=no delivery", inst);
    end else begin
      last = sb.pop_front();
      chk("inst", inst, last.inst);
      chk("inst_pc", inst_pc, last.pc);
    end
  endtask

  // One delivered fetch: gnt after gd stall cycles, rvalid rd cycles after gnt.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data,
                           input int gd, input int rd);
    chk("req", {31'd0, mem_req}, 32'd1);
    chk("addr", mem_addr, addr);
    repeat (gd) begin
      @(negedge clk);
      chk("req_hold", {31'd0, mem_req}, 32'd1);
      chk("addr_hold", mem_addr, addr);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("wait_noreq", {31'd0, mem_req}, 32'd0);
    repeat (rd) begin
      @(negedge clk);
      chk("wait_noreq_stall", {31'd0, mem_req}, 32'd0);
      chk("wait_novalid", {31'd0, inst_valid}, 32'd0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    sb.push_back(exp_t'{inst: data, pc: addr});
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check_out();
  endtask

  task automatic consume(input logic [31:0] next_addr);
    inst_ready = 1'b1;
    exp_cnt++;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("valid_clr", {31'd0, inst_valid}, 32'd0);
    chk("fetch_cnt", fetch_cnt, exp_cnt);
    chk("next_req", {31'd0, mem_req}, 32'd1);
    chk("next_addr", mem_addr, next_addr);
  endtask

  initial begin
    rst            = 1'b1;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_addr", mem_addr, 32'h8000_0000);
    rst = 1'b0;
    @(negedge clk);

    // First fetch, immediate grant, response next cycle
    fetch_one(32'h8000_0000, 32'h0000_0093, 0, 0);
    consume(32'h8000_0004);

    // Grant stalled 3 cycles, response delayed 2 cycles
    fetch_one(32'h8000_0004, 32'h1234_5678, 3, 2);

    // HOLD stability with inst_ready low
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_inst", inst, last.inst);
      chk("hold_pc", inst_pc, last.pc);
    end

    // Redirect together with inst_ready in HOLD
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    consume(32'h8000_0300);
    redirect_valid = 1'b0;

    // Redirect in WAIT with rvalid the same cycle
    chk("w_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    mem_rvalid     = 1'b1;
    mem_rdata      = 32'hDEAD_BEEF;
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_rvalid     = 1'b0;
    chk("w_valid", {31'd0, inst_valid}, 32'd0);
    chk("w_req2", {31'd0, mem_req}, 32'd1);
    chk("w_addr", mem_addr, 32'h8000_0100);
    chk("w_cnt", fetch_cnt, exp_cnt);

    // Back-to-back redirects in REQ while grant is stalled
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0180;
    @(negedge clk);
    redirect_pc    = 32'h8000_0200;
    chk("r_addr_hold1", mem_addr, 32'h8000_0100);
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("r_addr_hold2", mem_addr, 32'h8000_0100);
    chk("r_req_hold", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("r_wait", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("r_discard", {31'd0, inst_valid}, 32'd0);
    fetch_one(32'h8000_0200, 32'h1111_1111, 0, 0);
    consume(32'h8000_0204);

    // Redirect with grant in the same cycle, to the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    mem_gnt        = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_gnt        = 1'b0;
    chk("g_wait", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("g_discard", {31'd0, inst_valid}, 32'd0);
    fetch_one(32'hFFFF_FFFC, 32'h2222_2222, 0, 1);
    consume(32'h0000_0000);

    // Reset in WAIT, then a stale response right after release
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst     = 1'b1;
    #1;
    exp_cnt = 0;
    chk("mr_req", {31'd0, mem_req}, 32'd0);
    chk("mr_cnt", fetch_cnt, exp_cnt);
    chk("mr_valid", {31'd0, inst_valid}, 32'd0);
    chk("mr_addr", mem_addr, 32'h8000_0000);
    @(negedge clk);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h4444_4444;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stale_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("stale_valid2", {31'd0, inst_valid}, 32'd0);
    fetch_one(32'h8000_0000, 32'h3333_3333, 0, 0);
    consume(32'h8000_0004);

    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpc_fetch_ctrl.md
Name: gpc_fetch_ctrl

Overview:
Instruction-fetch sequencer for the GPC core. It owns the fetch PC and drives a request/grant/response instruction-memory port with one outstanding transaction. It hands each returned instruction, with its PC, to the decode/execute stage over a valid/ready handshake. It also applies control-flow redirects from the execute stage, discarding any in-flight fetch as needed.

Parameters:
WIDTH, 32, address/PC width
INST_MAX, 32, instruction width
PC_START, 32'h80000000, fetch PC loaded on reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
mem_req  output  1  fetch request to instruction memory
mem_addr  output  WIDTH  fetch address, word aligned
mem_gnt  input  1  memory accepted request this cycle
mem_rvalid  input  1  response data valid
mem_rdata  input  INST_MAX  returned instruction
redirect_valid  input  1  execute stage requests PC change
redirect_pc  input  WIDTH  redirect target
inst_valid  output  1  inst/inst_pc valid to core
inst  output  INST_MAX  fetched instruction
inst_pc  output  WIDTH  PC of inst
inst_ready  input  1  core consumes inst this cycle
fetch_cnt  output  32  retired-fetch counter (handshakes completed)

Behaviour:
- Reset (async, any state): state=REQ, fetch_pc=PC_START, kill=0, inst_valid=0, inst=0, inst_pc=0, fetch_cnt=0. mem_req is 0 while rst is high. It goes to 1 in the first cycle after rst deasserts.
- The state machine has three states: REQ, WAIT_R and HOLD.
- REQ: mem_req=1 and mem_addr=fetch_pc. mem_addr must stay stable until mem_gnt. On mem_gnt, go to WAIT_R.
- WAIT_R: mem_req=0. On mem_rvalid with kill=0, the following happens at the next edge:
  - inst is loaded from mem_rdata and inst_pc from fetch_pc.
  - inst_valid is set to 1 and the state goes to HOLD.
  - fetch_pc advances by 4.
- WAIT_R with kill=1: mem_rvalid clears kill, the state returns to REQ, and the data is discarded.
- HOLD: inst_valid=1 and the outputs are stable. On inst_ready, inst_valid goes to 0, the state goes to REQ and fetch_cnt increments.
- Best-case throughput is one instruction per 3 cycles (REQ with gnt, WAIT_R with rvalid, HOLD with ready). No combinational path exists from mem_rdata to inst.
- PC arithmetic is modulo 2^WIDTH: 32'hFFFFFFFC+4 wraps to 0. redirect_pc[1:0] is forced to 0.
- Redirect in REQ, without gnt in the same cycle: the request stays asserted with the old address, and the new PC is held in pend_pc with pend=1. When gnt arrives, set kill=1 and go to WAIT_R. After the discarded response, REQ issues pend_pc and clears pend.
- Redirect in REQ, with gnt in the same cycle: kill=1, fetch_pc is replaced by the redirect target, and the state goes to WAIT_R.
- Redirect in WAIT_R: kill=1 and fetch_pc is replaced by the redirect target.
  - If mem_rvalid arrives in the same cycle, the response is discarded and the state goes to REQ with the new PC.
- Redirect in HOLD: inst_valid goes to 0 next cycle, fetch_pc becomes the redirect target, and the state goes to REQ. If inst_ready is high in the same cycle, the handshake still counts (fetch_cnt increments); the redirect decides the next PC.
- Back-to-back redirects: the most recent target wins.
- Only one transaction is ever outstanding, so at most one response is discarded per kill.
- Reset mid-transaction: state and outputs return to their reset values immediately. A late mem_rvalid arriving in REQ is ignored.
- fetch_cnt wraps at 2^32.

Decomposition:
- Shared package gpc_pkg:
  - fetch state encoding: FS_REQ=2'd0, FS_WAIT=2'd1, FS_HOLD=2'd2
  - INST_BYTES=4 constant
  - NOP instruction constant 32'h00000013, for later bubble insertion
- Sub-module: none required. The PC register update (sequential +4 / redirect / pending) may be factored into gpc_fetch_pc_next, a purely combinational next-PC mux, if reuse with PC32 is wanted.

Test Plan:
- Reset release, memory grants immediately and responds 1 cycle later with 32'h00000093:
  - first mem_addr=32'h80000000
  - inst_valid with inst_pc=32'h80000000
  - inst_ready=1 → next mem_addr=32'h80000004, fetch_cnt=1
- gnt delayed 3 cycles: mem_addr stays at 32'h80000004 and mem_req stays high throughout. No second request is issued before rvalid.
- Redirect to 32'h80000103 while in WAIT_R, rvalid in the same cycle with 32'hDEADBEEF:
  - inst_valid stays 0
  - next mem_addr=32'h80000100 (low bits cleared)
  - fetch_cnt unchanged
- Redirect to 32'h80000200 in REQ while gnt is stalled:
  - mem_addr holds its old value until gnt
  - the first response is discarded
  - the next request goes to 32'h80000200
- In HOLD, inst_ready=0 for 5 cycles: inst/inst_pc remain stable. Then redirect together with inst_ready → fetch_cnt increments and the next request goes to the redirect target.
- Redirect to 32'hFFFFFFFC, then a normal fetch and consume → next mem_addr=0. Assert rst mid WAIT_R → mem_req=0 immediately. After release, mem_addr=32'h80000000 and a stale rvalid is ignored.
